// File: rtl/io_bridge.sv
// io_bridge: CPU IO-channel responder with RX/TX byte FIFOs, UART TX sequencer and error status.
module io_bridge #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] io_in_data,
    input  logic       io_in_rdy,
    output logic       io_in_vld,
    input  logic [7:0] io_out_data,
    output logic       io_out_rdy,
    input  logic       io_out_vld,
    output logic [4:0] io_err,
    input  logic       err_clr,
    input  logic [7:0] rx_data,
    input  logic       rx_stb,
    input  logic       rx_ferr,
    output logic [7:0] tx_data,
    output logic       tx_start,
    input  logic       tx_busy
);
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_HOLD, S_WAIT} tx_state_t;
    localparam logic [AW:0] FULL = DEPTH[AW:0];
    logic [7:0]    rx_mem [DEPTH];
    logic [7:0]    tx_mem [DEPTH];
    logic [AW-1:0] rx_wr, rx_rd, tx_wr, tx_rd;
    logic [AW:0]   rx_count, tx_count;
    logic [2:0]    sticky, events;
    logic          rx_full, tx_full, rx_push, rx_pop, tx_push, tx_pop, stalled;
    tx_state_t     state, next;
    assign rx_full    = rx_count == FULL;
    assign tx_full    = tx_count == FULL;
    assign io_in_vld  = rx_count != '0;
    assign io_in_data = rx_mem[rx_rd];
    assign io_out_rdy = !tx_full;
    assign rx_pop     = io_in_rdy & io_in_vld;
    assign rx_push    = rx_stb & (!rx_full | rx_pop);
    assign tx_push    = io_out_vld & io_out_rdy;
    assign tx_pop     = state == S_LOAD;
    assign tx_start   = state == S_LOAD;
    assign events     = {stalled & !io_out_vld, rx_stb & rx_ferr, rx_stb & rx_full & !rx_pop};
    assign io_err     = {tx_full, rx_full, sticky};
    always_comb begin
        next = state;
        next = (state == S_IDLE) ? ((tx_count != '0 && !tx_busy) ? S_LOAD : S_IDLE) :
               (state == S_LOAD) ? S_HOLD :
               (state == S_HOLD) ? S_WAIT :
               (tx_busy ? S_WAIT : S_IDLE);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_mem   <= '{default: '0};
            rx_wr    <= '0;
            rx_rd    <= '0;
            rx_count <= '0;
        end else begin
            if (rx_push) begin
                rx_mem[rx_wr] <= rx_data;
                rx_wr         <= rx_wr + 1'b1;
            end
            if (rx_pop)
                rx_rd <= rx_rd + 1'b1;
            rx_count <= rx_count + (AW+1)'(rx_push) - (AW+1)'(rx_pop);
        end
    end
    // tx_data is captured on entry to LOAD so it is already valid during the tx_start pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_mem   <= '{default: '0};
            tx_wr    <= '0;
            tx_rd    <= '0;
            tx_count <= '0;
            tx_data  <= '0;
            state    <= S_IDLE;
        end else begin
            if (tx_push) begin
                tx_mem[tx_wr] <= io_out_data;
                tx_wr         <= tx_wr + 1'b1;
            end
            if (tx_pop)
                tx_rd <= tx_rd + 1'b1;
            if (state == S_IDLE && next == S_LOAD)
                tx_data <= tx_mem[tx_rd];
            tx_count <= tx_count + (AW+1)'(tx_push) - (AW+1)'(tx_pop);
            state    <= next;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky  <= '0;
            stalled <= 1'b0;
        end else begin
            sticky  <= (sticky & {3{~err_clr}}) | events;
            stalled <= io_out_vld & !io_out_rdy;
        end
    end
endmodule

// File: tb/tb_io_bridge.sv
// tb_io_bridge: directed scenario tests for io_bridge with a simple UART busy model.
module tb_io_bridge;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] io_in_data;
    logic       io_in_rdy = 1'b0;
    logic       io_in_vld;
    logic [7:0] io_out_data = '0;
    logic       io_out_rdy;
    logic       io_out_vld = 1'b0;
    logic [4:0] io_err;
    logic       err_clr = 1'b0;
    logic [7:0] rx_data = '0;
    logic       rx_stb = 1'b0;
    logic       rx_ferr = 1'b0;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy;
    logic       busy_stuck = 1'b0;
    int         busy_cnt;
    int         n_start;
    int         cycle;
    logic [7:0] start_data [0:63];
    int         start_cyc [0:63];
    int         errors = 0;
    int         checks = 0;

    io_bridge dut (
        .clk(clk), .rst(rst),
        .io_in_data(io_in_data), .io_in_rdy(io_in_rdy), .io_in_vld(io_in_vld),
        .io_out_data(io_out_data), .io_out_rdy(io_out_rdy), .io_out_vld(io_out_vld),
        .io_err(io_err), .err_clr(err_clr),
        .rx_data(rx_data), .rx_stb(rx_stb), .rx_ferr(rx_ferr),
        .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy)
    );

    always #5 clk = ~clk;

    // UART model: busy for 10 cycles after each start pulse; logs every pulse
    assign tx_busy = busy_stuck | (busy_cnt != 0);
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_cnt <= 0;
        end else if (tx_start) begin
            busy_cnt <= 10;
        end else if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 1;
        end
    end
    initial n_start = 0;
    initial cycle = 0;
    always @(posedge clk) begin
        cycle <= cycle + 1;
        if (tx_start) begin
            start_data[n_start[5:0]] <= tx_data;
            start_cyc[n_start[5:0]]  <= cycle;
            n_start                  <= n_start + 1;
        end
    end

    task automatic clear_errs();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({io_in_vld, io_in_data, tx_start, tx_data, io_err, io_out_rdy} !== {1'b0, 8'h00, 1'b0, 8'h00, 5'h00, 1'b1}) begin
            errors++;
            $display("FAIL reset: vld=%b data=%h start=%b txd=%h err=%b rdy=%b, want 0 00 0 00 00000 1",
                     io_in_vld, io_in_data, tx_start, tx_data, io_err, io_out_rdy);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_rx_single();
        rx_data = 8'h41;
        rx_stb  = 1'b1;
        @(negedge clk);
        rx_stb  = 1'b0;
        checks++;
        if ({io_in_vld, io_in_data} !== {1'b1, 8'h41}) begin
            errors++;
            $display("FAIL rx_single_present: vld=%b data=%h, want 1 41", io_in_vld, io_in_data);
        end
        io_in_rdy = 1'b1;
        @(negedge clk);
        io_in_rdy = 1'b0;
        checks++;
        if (io_in_vld !== 1'b0) begin
            errors++;
            $display("FAIL rx_single_popped: vld=%b, want 0", io_in_vld);
        end
    endtask

    task automatic test_rx_overrun();
        for (int i = 0; i < 17; i++) begin
            rx_data = 8'(i);
            rx_stb  = 1'b1;
            @(negedge clk);
        end
        rx_stb = 1'b0;
        checks++;
        if (io_err[3] !== 1'b1 || io_err[0] !== 1'b1) begin
            errors++;
            $display("FAIL rx_overrun_err: io_err=%b, want bit3=1 bit0=1", io_err);
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if ({io_in_vld, io_in_data} !== {1'b1, 8'(i)}) begin
                errors++;
                $display("FAIL rx_overrun_order[%0d]: vld=%b data=%h, want 1 %h", i, io_in_vld, io_in_data, 8'(i));
            end
            io_in_rdy = 1'b1;
            @(negedge clk);
        end
        io_in_rdy = 1'b0;
        checks++;
        if (io_in_vld !== 1'b0 || io_err[3] !== 1'b0) begin
            errors++;
            $display("FAIL rx_overrun_drained: vld=%b err3=%b, want 0 0", io_in_vld, io_err[3]);
        end
        clear_errs();
        checks++;
        if (io_err !== 5'b0) begin
            errors++;
            $display("FAIL rx_err_clr: io_err=%b, want 00000", io_err);
        end
    endtask

    task automatic test_rx_full_pushpop();
        for (int i = 0; i < 16; i++) begin
            rx_data = 8'(i);
            rx_stb  = 1'b1;
            @(negedge clk);
        end
        rx_data   = 8'hEE;
        io_in_rdy = 1'b1;
        @(negedge clk);
        rx_stb    = 1'b0;
        io_in_rdy = 1'b0;
        checks++;
        if ({io_err, io_in_data} !== {5'b01000, 8'h01}) begin
            errors++;
            $display("FAIL rx_full_pushpop: io_err=%b data=%h, want 01000 01", io_err, io_in_data);
        end
        for (int i = 1; i <= 16; i++) begin
            checks++;
            if ({io_in_vld, io_in_data} !== {1'b1, (i == 16) ? 8'hEE : 8'(i)}) begin
                errors++;
                $display("FAIL rx_full_drain[%0d]: vld=%b data=%h", i, io_in_vld, io_in_data);
            end
            io_in_rdy = 1'b1;
            @(negedge clk);
        end
        io_in_rdy = 1'b0;
        checks++;
        if (io_in_vld !== 1'b0) begin
            errors++;
            $display("FAIL rx_full_empty: vld=%b, want 0", io_in_vld);
        end
    endtask

    task automatic test_back_to_back();
        int base;
        base        = n_start;
        io_out_vld  = 1'b1;
        io_out_data = 8'h55;
        @(negedge clk);
        io_out_data = 8'hAA;
        @(negedge clk);
        io_out_vld  = 1'b0;
        for (int i = 0; i < 60; i++) @(negedge clk);
        checks++;
        if (n_start - base !== 2) begin
            errors++;
            $display("FAIL b2b_count: starts=%0d, want 2", n_start - base);
        end else begin
            checks++;
            if (start_data[base[5:0]] !== 8'h55 || start_data[6'(base + 1)] !== 8'hAA) begin
                errors++;
                $display("FAIL b2b_data: got %h %h, want 55 aa", start_data[base[5:0]], start_data[6'(base + 1)]);
            end
            checks++;
            if (start_cyc[6'(base + 1)] - start_cyc[base[5:0]] < 3) begin
                errors++;
                $display("FAIL b2b_gap: gap=%0d, want >=3", start_cyc[6'(base + 1)] - start_cyc[base[5:0]]);
            end
        end
    endtask

    task automatic test_tx_full_protocol();
        busy_stuck = 1'b1;
        io_out_vld = 1'b1;
        for (int i = 0; i < 16; i++) begin
            io_out_data = 8'(8'h10 + i);
            @(negedge clk);
        end
        checks++;
        if (io_out_rdy !== 1'b0 || io_err[4] !== 1'b1) begin
            errors++;
            $display("FAIL tx_full: rdy=%b err4=%b, want 0 1", io_out_rdy, io_err[4]);
        end
        @(negedge clk);
        checks++;
        if (io_err[2] !== 1'b0) begin
            errors++;
            $display("FAIL tx_stall_noerr: err2=%b, want 0", io_err[2]);
        end
        io_out_vld = 1'b0;
        @(negedge clk);
        checks++;
        if (io_err[2] !== 1'b1) begin
            errors++;
            $display("FAIL tx_protocol_err: err2=%b, want 1", io_err[2]);
        end
        clear_errs();
        checks++;
        if (io_err !== 5'b10000) begin
            errors++;
            $display("FAIL tx_err_clr: io_err=%b, want 10000", io_err);
        end
    endtask

    task automatic test_reset_mid_tx();
        int base;
        base       = n_start;
        busy_stuck = 1'b0;
        for (int i = 0; i < 20 && n_start == base; i++) @(negedge clk);
        checks++;
        if (n_start !== base + 1) begin
            errors++;
            $display("FAIL midtx_start: starts=%0d, want 1", n_start - base);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({io_in_vld, io_in_data, tx_start, tx_data, io_err, io_out_rdy} !== {1'b0, 8'h00, 1'b0, 8'h00, 5'h00, 1'b1}) begin
            errors++;
            $display("FAIL midtx_reset: vld=%b data=%h start=%b txd=%h err=%b rdy=%b, want 0 00 0 00 00000 1",
                     io_in_vld, io_in_data, tx_start, tx_data, io_err, io_out_rdy);
        end
        @(negedge clk);
        @(negedge clk);
        rst  = 1'b0;
        base = n_start;
        for (int i = 0; i < 30; i++) @(negedge clk);
        checks++;
        if (n_start !== base || io_out_rdy !== 1'b1 || io_err !== 5'b0) begin
            errors++;
            $display("FAIL midtx_after: starts=%0d rdy=%b err=%b, want 0 1 00000", n_start - base, io_out_rdy, io_err);
        end
    endtask

    initial begin
        test_reset();
        test_rx_single();
        test_rx_overrun();
        test_rx_full_pushpop();
        test_back_to_back();
        test_tx_full_protocol();
        test_reset_mid_tx();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
